muldiv_sequencer: RTL and testbench
===================================

// Module: muldiv_sequencer
// PURPOSE
//  Multi-cycle HI/LO unit beside the Execute stage. Owns the HI/LO registers.
//  Sequences iterative DIV/DIVU, and optionally MULT/MULTU, one bit per cycle.
//  Raises a stall to the pipeline while MFHI/MFLO or a new HI/LO op must wait for a result in flight.
//  Replaces the single-cycle "/" and "%" in Execute; Execute forwards its requests here.
// PARAMETERS
//  WIDTH  32  operand/result width; bit 0 is MSB (vectors declared [0:WIDTH-1])
//  CNT_W  6   iteration counter width; must hold WIDTH
// PORTS
//  clock      in   1      single clock; all state updates on posedge
//  reset      in   1      synchronous, active-high
//  start      in   1      Execute issues an HI/LO op this cycle (valid_ex & op decode)
//  op         in   2      00 DIV, 01 DIVU, 10 MULT, 11 MULTU
//  opa        in   32     rs value (dividend / multiplicand)
//  opb        in   32     rt value (divisor / multiplier)
//  mf_req     in   1      MFHI or MFLO is in Execute this cycle
//  busy       out  1      operation in flight
//  stall      out  1      comb: busy & (start | mf_req)
//  done       out  1      one-cycle pulse on the cycle HI/LO are written
//  div_zero   out  1      pulses with done when the divisor was 0
//  hi         out  32     HI register (remainder / product upper)
//  lo         out  32     LO register (quotient / product lower)
// BEHAVIOUR
//  - Reset: state IDLE; hi = lo = 0; busy = done = div_zero = 0; counter = 0. Reset mid-operation aborts the op; no HI/LO write.
//  - FSM IDLE -> PREP -> ITER -> FIXUP -> IDLE.
//  - IDLE: start=1 latches op, opa, opb; next state PREP; busy=1 from the next cycle.
//  - PREP: computes operand magnitudes for signed ops and result sign flags; loads counter = WIDTH.
//      If divide and opb==0, goes directly to FIXUP (div-by-zero path); otherwise goes to ITER.
//  - ITER: one restoring-divide or shift-add step per cycle; counter decrements; leaves at counter==1 -> FIXUP.
//  - FIXUP: applies sign correction and writes hi/lo. done=1 (registered, this cycle). Next state IDLE; busy=0 from the next cycle.
//  - Latency: start sampled at edge E; hi/lo valid and done high after edge E+WIDTH+2 (34 for 32).
//      Div-by-zero completes after edge E+2.
//  - Divide results: lo = quotient truncated toward zero; hi = remainder with the sign of the dividend.
//  - Signed overflow: 0x80000000 / 0xFFFFFFFF -> lo = 0x80000000, hi = 0.
//  - Div-by-zero: lo = 0xFFFFFFFF, hi = opa; div_zero pulses with done.
//  - start while busy: not accepted; stall=1; the requester holds start until busy falls.
//      start in the cycle busy falls (FIXUP) is still stalled; it is accepted the following cycle.
//  - mf_req while busy: stall=1 through FIXUP; hi/lo are read the cycle after done.
//  - mf_req when idle: no stall; hi/lo reflect the last completed op.
//  - hi/lo change only in FIXUP or on reset.
// CONFIGURATION
//  - MULDIV_MULT_EN defined: MULT/MULTU run the shift-add path (same latency as divide).
//      {hi,lo} = 64-bit product, signed for MULT.
//  - MULDIV_MULT_EN undefined: op 1x goes IDLE -> FIXUP. done pulses after edge E+1; hi/lo unchanged; no mult datapath synthesised.
// STRUCTURE
//  - Shared include muldiv.vh (alongside control.vh) holds:
//      op encodings MD_DIV/MD_DIVU/MD_MULT/MD_MULTU
//      state encodings S_IDLE/S_PREP/S_ITER/S_FIXUP
//      constant MD_ITERS
//  - Sub-module muldiv_step: combinational single iteration.
//      Inputs: partial remainder/accumulator, shifted operand, mode.
//      Outputs: next remainder/accumulator and quotient bit.
//  - The sequencer holds the FSM, counter, operand latches and HI/LO.
// TESTING
//  1. DIVU opa=100, opb=7 -> done after edge E+34; lo=14, hi=2; busy low next cycle.
//  2. DIV opa=0xFFFFFFF9 (-7), opb=2 -> lo=0xFFFFFFFD (-3), hi=0xFFFFFFFF (-1).
//  3. DIV opa=5, opb=0 -> done and div_zero after edge E+2; lo=0xFFFFFFFF, hi=5.
//  4. DIV in flight, mf_req=1 and second start=1 held -> stall=1 every cycle through FIXUP.
//      Second op accepted the cycle after done; MFHI reads the first op's remainder.
//  5. reset=1 at ITER cycle 10 -> next cycle busy=0, hi=lo=0, no done.
//      A following DIVU 9/3 gives lo=3, hi=0.
//  6. MULDIV_MULT_EN: MULT 0xFFFFFFFD x 5 -> hi=0xFFFFFFFF, lo=0xFFFFFFF1 after edge E+34.
//      Without the macro: done after edge E+1, hi/lo unchanged.

Source files
------------

// File: rtl/muldiv_sequencer_pkg.sv
// Shared encodings for the HI/LO multi-cycle unit: op codes, FSM states,
// iteration count, step modes and small op-decode helpers.
package muldiv_sequencer_pkg;

   localparam int MD_ITERS = 32;

   typedef logic [1:0] md_op_t;

   localparam md_op_t MD_DIV   = 2'b00;
   localparam md_op_t MD_DIVU  = 2'b01;
   localparam md_op_t MD_MULT  = 2'b10;
   localparam md_op_t MD_MULTU = 2'b11;

   localparam logic [1:0] S_IDLE  = 2'b00;
   localparam logic [1:0] S_PREP  = 2'b01;
   localparam logic [1:0] S_ITER  = 2'b10;
   localparam logic [1:0] S_FIXUP = 2'b11;

   typedef enum logic [0:0] {
      STEP_DIV  = 1'b0,
      STEP_MULT = 1'b1
   } step_mode_e;

   function automatic logic md_is_div(input md_op_t op);
      return (op == MD_DIV) || (op == MD_DIVU);
   endfunction

   function automatic logic md_is_signed(input md_op_t op);
      return (op == MD_DIV) || (op == MD_MULT);
   endfunction

endpackage

// File: rtl/muldiv_sequencer_if.sv
// Execute-to-HI/LO-unit request/response bundle. Operand and result vectors
// are MSB-first ([0:WIDTH-1]); Execute is the master, the sequencer the slave.
interface muldiv_sequencer_if
   import muldiv_sequencer_pkg::*;
#(
   parameter int WIDTH = MD_ITERS
);
   logic             start;
   md_op_t           op;
   logic [0:WIDTH-1] opa;
   logic [0:WIDTH-1] opb;
   logic             mf_req;
   logic             busy;
   logic             stall;
   logic             done;
   logic             div_zero;
   logic [0:WIDTH-1] hi;
   logic [0:WIDTH-1] lo;

   modport master (
      output start, op, opa, opb, mf_req,
      input  busy, stall, done, div_zero, hi, lo
   );

   modport slave (
      input  start, op, opa, opb, mf_req,
      output busy, stall, done, div_zero, hi, lo
   );

endinterface

// File: rtl/muldiv_sequencer_step.sv
// Single combinational iteration: restoring-divide step, plus an LSB-first
// shift-add step when MULDIV_MULT_EN is defined.
module muldiv_sequencer_step
   import muldiv_sequencer_pkg::*;
#(
   parameter int WIDTH = MD_ITERS
)(
   input  logic [0:WIDTH-1] acc_i,
   input  logic             shq_msb_i,
`ifdef MULDIV_MULT_EN
   input  logic             shq_lsb_i,
   input  step_mode_e       mode_i,
`endif
   input  logic [0:WIDTH-1] m_i,
   output logic [0:WIDTH-1] acc_o,
   output logic             qbit_o
);

   logic [0:WIDTH] sh_s;
   logic [0:WIDTH] diff_s;

   assign sh_s   = {acc_i, shq_msb_i};
   assign diff_s = sh_s - {1'b0, m_i};

`ifdef MULDIV_MULT_EN
   logic [0:WIDTH] sum_s;

   // For multiply, qbit_o is the sum bit that shifts into the product's low word.
   assign sum_s = {1'b0, acc_i} + (shq_lsb_i ? {1'b0, m_i} : {(WIDTH + 1){1'b0}});
`endif

   // Select restore/subtract (divide) or add/shift (multiply) result.
   always_comb begin
      acc_o  = sh_s[1:WIDTH];
      qbit_o = 1'b0;
`ifdef MULDIV_MULT_EN
      if (mode_i == STEP_MULT) begin
         acc_o  = sum_s[0:WIDTH-1];
         qbit_o = sum_s[WIDTH];
      end else if (!diff_s[0]) begin
         acc_o  = diff_s[1:WIDTH];
         qbit_o = 1'b1;
      end else begin
         acc_o  = sh_s[1:WIDTH];
         qbit_o = 1'b0;
      end
`else
      if (!diff_s[0]) begin
         acc_o  = diff_s[1:WIDTH];
         qbit_o = 1'b1;
      end else begin
         acc_o  = sh_s[1:WIDTH];
         qbit_o = 1'b0;
      end
`endif
   end

endmodule

// File: rtl/muldiv_sequencer.sv
// Multi-cycle HI/LO unit beside Execute: iterative DIV/DIVU and, with
// MULDIV_MULT_EN defined, MULT/MULTU; owns HI/LO and raises pipeline stall.
module muldiv_sequencer
   import muldiv_sequencer_pkg::*;
#(
   parameter int WIDTH = MD_ITERS,
   parameter int CNT_W = 6
)(
   input  logic              clock_i,
   input  logic              reset_i,
   muldiv_sequencer_if.slave md
);

   logic [1:0]       state_q, state_d;
   md_op_t           op_q, op_d;
   logic [0:WIDTH-1] opa_q, opa_d;
   logic [0:WIDTH-1] opb_q, opb_d;
   logic [0:WIDTH-1] acc_q, acc_d;
   logic [0:WIDTH-1] shq_q, shq_d;
   logic [0:WIDTH-1] m_q, m_d;
   logic [CNT_W-1:0] cnt_q, cnt_d;
   logic             neg_lo_q, neg_lo_d;
   logic             neg_hi_q, neg_hi_d;
   logic [0:WIDTH-1] hi_q, hi_d;
   logic [0:WIDTH-1] lo_q, lo_d;
   logic             done_q, done_d;
   logic             dz_q, dz_d;
   logic [0:WIDTH-1] step_acc_s;
   logic             qbit_s;
   logic             busy_s;

`ifdef MULDIV_MULT_EN
   step_mode_e         mode_s;
   logic [0:2*WIDTH-1] prod_s;
   logic [0:2*WIDTH-1] prod_neg_s;

   assign mode_s     = md_is_div(op_q) ? STEP_DIV : STEP_MULT;
   assign prod_s     = {acc_q, shq_q};
   assign prod_neg_s = -prod_s;
`endif

   muldiv_sequencer_step #(.WIDTH(WIDTH)) u_step (
      .acc_i     (acc_q),
      .shq_msb_i (shq_q[0]),
`ifdef MULDIV_MULT_EN
      .shq_lsb_i (shq_q[WIDTH-1]),
      .mode_i    (mode_s),
`endif
      .m_i       (m_q),
      .acc_o     (step_acc_s),
      .qbit_o    (qbit_s)
   );

   assign busy_s      = (state_q != S_IDLE);
   assign md.busy     = busy_s;
   assign md.stall    = busy_s & (md.start | md.mf_req);
   assign md.done     = done_q;
   assign md.div_zero = dz_q;
   assign md.hi       = hi_q;
   assign md.lo       = lo_q;

   // Next-state and datapath sequencing for the HI/LO FSM.
   always_comb begin
      state_d  = state_q;
      op_d     = op_q;
      opa_d    = opa_q;
      opb_d    = opb_q;
      acc_d    = acc_q;
      shq_d    = shq_q;
      m_d      = m_q;
      cnt_d    = cnt_q;
      neg_lo_d = neg_lo_q;
      neg_hi_d = neg_hi_q;
      hi_d     = hi_q;
      lo_d     = lo_q;
      done_d   = 1'b0;
      dz_d     = 1'b0;
      case (state_q)
         S_IDLE: begin
            if (md.start) begin
               op_d  = md.op;
               opa_d = md.opa;
               opb_d = md.opb;
`ifdef MULDIV_MULT_EN
               state_d = S_PREP;
`else
               state_d = md_is_div(md.op) ? S_PREP : S_FIXUP;
`endif
            end else begin
               state_d = S_IDLE;
            end
         end
         S_PREP: begin
            acc_d    = {WIDTH{1'b0}};
            shq_d    = (md_is_signed(op_q) && opa_q[0]) ? -opa_q : opa_q;
            m_d      = (md_is_signed(op_q) && opb_q[0]) ? -opb_q : opb_q;
            neg_lo_d = md_is_signed(op_q) & (opa_q[0] ^ opb_q[0]);
            neg_hi_d = md_is_signed(op_q) & opa_q[0];
            cnt_d    = CNT_W'(WIDTH);
            if (md_is_div(op_q) && (opb_q == {WIDTH{1'b0}})) begin
               state_d = S_FIXUP;
            end else begin
               state_d = S_ITER;
            end
         end
         S_ITER: begin
            acc_d = step_acc_s;
`ifdef MULDIV_MULT_EN
            if (mode_s == STEP_MULT) begin
               shq_d = {qbit_s, shq_q[0:WIDTH-2]};
            end else begin
               shq_d = {shq_q[1:WIDTH-1], qbit_s};
            end
`else
            shq_d = {shq_q[1:WIDTH-1], qbit_s};
`endif
            cnt_d = cnt_q - CNT_W'(1);
            if (cnt_q == CNT_W'(1)) begin
               state_d = S_FIXUP;
            end else begin
               state_d = S_ITER;
            end
         end
         S_FIXUP: begin
            state_d = S_IDLE;
            done_d  = 1'b1;
            if (md_is_div(op_q)) begin
               // Divide by zero returns all-ones quotient and the raw dividend.
               if (opb_q == {WIDTH{1'b0}}) begin
                  lo_d = {WIDTH{1'b1}};
                  hi_d = opa_q;
                  dz_d = 1'b1;
               end else begin
                  lo_d = neg_lo_q ? -shq_q : shq_q;
                  hi_d = neg_hi_q ? -acc_q : acc_q;
               end
            end else begin
`ifdef MULDIV_MULT_EN
               {hi_d, lo_d} = neg_lo_q ? prod_neg_s : prod_s;
`else
               hi_d = hi_q;
               lo_d = lo_q;
`endif
            end
         end
         default: begin
            state_d = S_IDLE;
         end
      endcase
   end

   // State registers with synchronous active-high reset.
   always_ff @(posedge clock_i) begin
      if (reset_i) begin
         state_q  <= S_IDLE;
         op_q     <= MD_DIV;
         opa_q    <= {WIDTH{1'b0}};
         opb_q    <= {WIDTH{1'b0}};
         acc_q    <= {WIDTH{1'b0}};
         shq_q    <= {WIDTH{1'b0}};
         m_q      <= {WIDTH{1'b0}};
         cnt_q    <= {CNT_W{1'b0}};
         neg_lo_q <= 1'b0;
         neg_hi_q <= 1'b0;
         hi_q     <= {WIDTH{1'b0}};
         lo_q     <= {WIDTH{1'b0}};
         done_q   <= 1'b0;
         dz_q     <= 1'b0;
      end else begin
         state_q  <= state_d;
         op_q     <= op_d;
         opa_q    <= opa_d;
         opb_q    <= opb_d;
         acc_q    <= acc_d;
         shq_q    <= shq_d;
         m_q      <= m_d;
         cnt_q    <= cnt_d;
         neg_lo_q <= neg_lo_d;
         neg_hi_q <= neg_hi_d;
         hi_q     <= hi_d;
         lo_q     <= lo_d;
         done_q   <= done_d;
         dz_q     <= dz_d;
      end
   end

endmodule

// File: tb/tb_muldiv_sequencer.sv
// Scoreboard bench for muldiv_sequencer: directed ops push expected HI/LO and
// completion edge; a negedge monitor pops on every done pulse and compares.
module tb_muldiv_sequencer;
   import muldiv_sequencer_pkg::*;

   typedef struct {
      string       name;
      logic [31:0] hi;
      logic [31:0] lo;
      logic        dz;
      int          edge_n;
   } exp_t;

   logic clk = 1'b0;
   logic rst = 1'b1;
   int   checks = 0;
   int   errors = 0;
   int   cyc = 0;
   int   done_cnt = 0;
   exp_t exp_q[$];

`ifdef MULDIV_MULT_EN
   localparam int MLAT = 34;
`else
   localparam int MLAT = 1;
`endif

   muldiv_sequencer_if #(.WIDTH(32)) md_if();

   muldiv_sequencer #(.WIDTH(32), .CNT_W(6)) dut (
      .clock_i (clk),
      .reset_i (rst),
      .md      (md_if)
   );

   always #5 clk = ~clk;

   always @(posedge clk) cyc <= cyc + 1;

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] req);
      checks++;
      if (act !== req) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h", nm, act, req);
      end
   endtask

   // Monitor: every done pulse must match the oldest outstanding expectation.
   always @(negedge clk) begin
      exp_t e;
      if (!rst && md_if.done === 1'b1) begin
         done_cnt++;
         if (exp_q.size() == 0) begin
            chk("spurious done", 32'd1, 32'd0);
         end else begin
            e = exp_q.pop_front();
            chk({e.name, " lo"}, md_if.lo, e.lo);
            chk({e.name, " hi"}, md_if.hi, e.hi);
            chk({e.name, " div_zero"}, 32'(md_if.div_zero), 32'(e.dz));
            chk({e.name, " done edge"}, cyc, e.edge_n);
         end
      end
   end

   task automatic expect_op(input string nm, input logic [31:0] ehi, input logic [31:0] elo,
                            input logic edz, input int edge_n);
      exp_t e;
      e.name = nm; e.hi = ehi; e.lo = elo; e.dz = edz; e.edge_n = edge_n;
      exp_q.push_back(e);
   endtask

   task automatic wait_done(input string nm);
      int n;
      n = 0;
      while (exp_q.size() != 0 && n < 60) begin
         @(negedge clk);
         n++;
      end
      chk({nm, " pending results"}, 32'(exp_q.size()), 32'd0);
      exp_q.delete();
      @(negedge clk);
      chk({nm, " busy after done"}, 32'(md_if.busy), 32'd0);
   endtask

   task automatic issue(input string nm, input logic [1:0] o, input logic [31:0] a,
                        input logic [31:0] b, input logic [31:0] ehi, input logic [31:0] elo,
                        input logic edz, input int lat);
      @(posedge clk); #1;
      md_if.start = 1'b1;
      md_if.op    = o;
      md_if.opa   = a;
      md_if.opb   = b;
      expect_op(nm, ehi, elo, edz, cyc + 1 + lat);
      @(posedge clk); #1;
      md_if.start = 1'b0;
      @(negedge clk);
      chk({nm, " busy in flight"}, 32'(md_if.busy), 32'd1);
      wait_done(nm);
   endtask

   initial begin
      int e1;
      int seen;
      int dc;
      md_if.start  = 1'b0;
      md_if.op     = MD_DIV;
      md_if.opa    = 32'd0;
      md_if.opb    = 32'd0;
      md_if.mf_req = 1'b0;

      repeat (3) @(posedge clk);
      @(negedge clk);
      chk("reset busy", 32'(md_if.busy), 32'd0);
      chk("reset done", 32'(md_if.done), 32'd0);
      chk("reset div_zero", 32'(md_if.div_zero), 32'd0);
      chk("reset stall", 32'(md_if.stall), 32'd0);
      chk("reset hi", md_if.hi, 32'd0);
      chk("reset lo", md_if.lo, 32'd0);
      rst = 1'b0;

      issue("divu 100/7", MD_DIVU, 32'd100, 32'd7, 32'd2, 32'd14, 1'b0, 34);
      issue("div -7/2", MD_DIV, 32'hFFFF_FFF9, 32'd2, 32'hFFFF_FFFF, 32'hFFFF_FFFD, 1'b0, 34);
      issue("div 7/-2", MD_DIV, 32'd7, 32'hFFFF_FFFE, 32'd1, 32'hFFFF_FFFD, 1'b0, 34);
      issue("div -7/-2", MD_DIV, 32'hFFFF_FFF9, 32'hFFFF_FFFE, 32'hFFFF_FFFF, 32'd3, 1'b0, 34);
      issue("div overflow", MD_DIV, 32'h8000_0000, 32'hFFFF_FFFF, 32'd0, 32'h8000_0000, 1'b0, 34);
      issue("divu max/16", MD_DIVU, 32'hFFFF_FFFF, 32'd16, 32'd15, 32'h0FFF_FFFF, 1'b0, 34);
      issue("div 5/0", MD_DIV, 32'd5, 32'd0, 32'd5, 32'hFFFF_FFFF, 1'b1, 2);
      issue("divu big/0", MD_DIVU, 32'hFFFF_FFFB, 32'd0, 32'hFFFF_FFFB, 32'hFFFF_FFFF, 1'b1, 2);

      // MF while idle: no stall, reads the last completed result.
      @(posedge clk); #1;
      md_if.mf_req = 1'b1;
      @(negedge clk);
      chk("idle mf stall", 32'(md_if.stall), 32'd0);
      chk("idle mf hi", md_if.hi, 32'hFFFF_FFFB);
      @(posedge clk); #1;
      md_if.mf_req = 1'b0;

      // First DIV in flight while MF and a second start are held.
      @(posedge clk); #1;
      md_if.start = 1'b1;
      md_if.op    = MD_DIV;
      md_if.opa   = 32'd1000;
      md_if.opb   = 32'd3;
      e1 = cyc + 1;
      expect_op("stall op1", 32'd1, 32'd333, 1'b0, e1 + 34);
      @(posedge clk); #1;
      md_if.op     = MD_DIVU;
      md_if.opa    = 32'd50;
      md_if.opb    = 32'd6;
      md_if.mf_req = 1'b1;
      expect_op("stall op2", 32'd2, 32'd8, 1'b0, e1 + 35 + 34);
      seen = 0;
      for (int n = 0; n < 60; n++) begin
         @(negedge clk);
         if (md_if.busy === 1'b1) begin
            chk("held stall", 32'(md_if.stall), 32'd1);
         end else begin
            chk("mfhi after op1", md_if.hi, 32'd1);
            chk("stall released", 32'(md_if.stall), 32'd0);
            seen = 1;
            break;
         end
      end
      chk("op1 completes", 32'(seen), 32'd1);
      @(posedge clk); #1;
      md_if.start  = 1'b0;
      md_if.mf_req = 1'b0;
      wait_done("stall ops");

      // Reset in the tenth ITER cycle aborts without writing HI/LO.
      @(posedge clk); #1;
      md_if.start = 1'b1;
      md_if.op    = MD_DIVU;
      md_if.opa   = 32'd1000;
      md_if.opb   = 32'd7;
      @(posedge clk); #1;
      md_if.start = 1'b0;
      dc = done_cnt;
      repeat (10) @(posedge clk);
      #1 rst = 1'b1;
      @(negedge clk);
      @(negedge clk);
      chk("abort busy", 32'(md_if.busy), 32'd0);
      chk("abort done", 32'(md_if.done), 32'd0);
      chk("abort hi", md_if.hi, 32'd0);
      chk("abort lo", md_if.lo, 32'd0);
      rst = 1'b0;
      repeat (40) @(negedge clk);
      chk("no done after abort", 32'(done_cnt - dc), 32'd0);

      issue("divu 9/3", MD_DIVU, 32'd9, 32'd3, 32'd0, 32'd3, 1'b0, 34);
      issue("divu 100/7 again", MD_DIVU, 32'd100, 32'd7, 32'd2, 32'd14, 1'b0, 34);

`ifdef MULDIV_MULT_EN
      issue("mult -3*5", MD_MULT, 32'hFFFF_FFFD, 32'd5, 32'hFFFF_FFFF, 32'hFFFF_FFF1, 1'b0, MLAT);
      issue("multu max*2", MD_MULTU, 32'hFFFF_FFFF, 32'd2, 32'd1, 32'hFFFF_FFFE, 1'b0, MLAT);
      issue("mult 7*6", MD_MULT, 32'd7, 32'd6, 32'd0, 32'd42, 1'b0, MLAT);
`else
      issue("mult -3*5", MD_MULT, 32'hFFFF_FFFD, 32'd5, 32'd2, 32'd14, 1'b0, MLAT);
      issue("multu max*2", MD_MULTU, 32'hFFFF_FFFF, 32'd2, 32'd2, 32'd14, 1'b0, MLAT);
      issue("mult 7*6", MD_MULT, 32'd7, 32'd6, 32'd2, 32'd14, 1'b0, MLAT);
`endif

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
